admo_alu_arb: RTL and testbench
===============================

ADMO_ALU_ARB -- requirements
Module: admo_alu_arb

Interface
REQ-001 SHALL have no Verilog parameters; all data widths SHALL be `DATA_WIDTH (32) from admo_defs.v, and operator codes SHALL be the `ALU_* codes from admo_defs.v.
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_ni  input  1  asynchronous, active-low reset.
REQ-004 req_valid_i  input  2  per-port request valid; bit i belongs to port i.
REQ-005 req_ready_o  output  2  per-port request accepted this cycle.
REQ-006 req_operand_a_i / req_operand_b_i  input  2x`DATA_WIDTH  per-port operands, packed with port 1 in the upper half.
REQ-007 req_operator_i  input  2x4  per-port `ALU_* code, packed with port 1 in the upper half.
REQ-008 alu_operand_a_o / alu_operand_b_o  output  `DATA_WIDTH  registered operands to the shared admo_alu.
REQ-009 alu_operator_o  output  4  registered operator to the shared admo_alu.
REQ-010 alu_result_i  input  `DATA_WIDTH  combinational result from admo_alu.
REQ-011 rsp_valid_o  output  2  per-port response valid.
REQ-012 rsp_ready_i  input  2  per-port response consumed.
REQ-013 rsp_result_o  output  2x`DATA_WIDTH  per-port held result.

Function
REQ-014 SHALL share one combinational ALU between 2 requesters with valid/ready handshakes on both the request and the response side.
REQ-015 Eligibility: port i eligible = req_valid_i[i] & ~busy[i]; busy[i] set on request handshake, cleared on response handshake (rsp_valid_o[i] & rsp_ready_i[i]).
REQ-016 At most one port granted per cycle; req_ready_o = grant (combinational from req_valid_i and registered state only; no path from rsp_ready_i).
REQ-017 Issue stage: on handshake in cycle N, operands, operator and port id SHALL be registered at edge N+1, with iss_valid set for exactly one cycle unless a new handshake occurs.
REQ-018 Capture stage: when iss_valid, alu_result_i SHALL be written at edge N+2 into port iss_port's response register, and rsp_valid_o[iss_port] set; latency request-handshake to rsp_valid_o = 2 cycles.
REQ-019 Response register SHALL hold value and rsp_valid_o until rsp_ready_i; at most one outstanding op per port, so the register can never be overwritten.
REQ-020 alu_* outputs SHALL hold their last value when no issue occurs (no toggling on idle).
REQ-021 Back-to-back issue SHALL be supported: alternating ports sustain 1 op/cycle on the ALU; a single port is limited by its busy flag.
REQ-022 Response handshake and new request handshake on the same port in the same cycle SHALL not occur (busy still set); a new request is accepted the cycle after busy clears.
REQ-023 Requester SHALL hold req_* stable while req_valid_i & ~req_ready_o; the bench SHALL check this as an assertion.
REQ-024 Simultaneous rsp_valid_o on both ports SHALL be independent; consumption order is free.

Reset
REQ-025 While rst_ni low: req_ready_o=0, rsp_valid_o=0, rsp_result_o=0, alu_operand_a_o=alu_operand_b_o=0, alu_operator_o=0, busy=0, iss_valid=0, rr pointer = "port 1 last".
REQ-026 Reset mid-operation SHALL discard in-flight issue and held responses; no response SHALL appear after reset release without a new handshake.

Configuration
REQ-027 Macro ADMO_ALU_ARB_RR_EN defined: round-robin; on contention, grant the port not granted last; pointer updates only on a handshake.
REQ-028 Macro ADMO_ALU_ARB_RR_EN undefined: fixed priority, port 0 always wins contention; rr pointer logic absent.

Verification
REQ-029 Port0 a=5 b=3 `ALU_ADD, rsp_ready_i=1 -> rsp_valid_o[0] exactly 2 cycles after handshake, rsp_result_o[0]=8, req_ready_o[0] low until the response is taken.
REQ-030 Both ports valid every cycle (RR_EN): port0 `ALU_SUB 10,4 / port1 `ALU_SLL 1,4 -> grants alternate 0,1,0,1; results 6 and 16.
REQ-031 Same as REQ-030 without RR_EN, port0 continuously eligible -> port0 wins every contention; port1 granted only while port0 busy.
REQ-032 Port1 `ALU_LTS a=0xFFFFFFFF b=1, rsp_ready_i[1]=0 for 10 cycles -> rsp_result_o[1]=1 held stable, no further port1 grant until rsp_ready_i[1]=1.
REQ-033 Assert rst_ni low one cycle after a port0 handshake -> all outputs at reset values asynchronously; no rsp_valid_o after release.

Source files
------------

// File: rtl/admo_alu_arb.sv
// admo_alu_arb: shares one combinational ALU between two requesters (2-cycle request-to-response latency).
// Define ADMO_ALU_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd0
`define ALU_SUB 4'd1
`define ALU_AND 4'd2
`define ALU_OR  4'd3
`define ALU_XOR 4'd4
`define ALU_SLL 4'd5
`define ALU_SRL 4'd6
`define ALU_SRA 4'd7
`define ALU_LTS 4'd8
`define ALU_LTU 4'd9
`endif
module admo_alu_arb (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [1:0]               req_valid_i,
  output logic [1:0]               req_ready_o,
  input  logic [2*`DATA_WIDTH-1:0] req_operand_a_i,
  input  logic [2*`DATA_WIDTH-1:0] req_operand_b_i,
  input  logic [7:0]               req_operator_i,
  output logic [`DATA_WIDTH-1:0]   alu_operand_a_o,
  output logic [`DATA_WIDTH-1:0]   alu_operand_b_o,
  output logic [3:0]               alu_operator_o,
  input  logic [`DATA_WIDTH-1:0]   alu_result_i,
  output logic [1:0]               rsp_valid_o,
  input  logic [1:0]               rsp_ready_i,
  output logic [2*`DATA_WIDTH-1:0] rsp_result_o
);
  logic [1:0] busy, elig, grant;
  logic       iss_valid, iss_port, gport;
  assign elig = req_valid_i & ~busy;
`ifdef ADMO_ALU_ARB_RR_EN
  logic rr_last;
  assign grant = &elig ? (rr_last ? 2'b01 : 2'b10) : elig;
`else
  assign grant = elig[0] ? 2'b01 : elig;
`endif
  assign gport       = grant[1];
  // Ready is masked by reset so no request is acknowledged while the block is held in reset.
  assign req_ready_o = grant & {2{rst_ni}};
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy            <= '0;
      iss_valid       <= 1'b0;
      iss_port        <= 1'b0;
      alu_operand_a_o <= '0;
      alu_operand_b_o <= '0;
      alu_operator_o  <= '0;
      rsp_valid_o     <= '0;
      rsp_result_o    <= '0;
`ifdef ADMO_ALU_ARB_RR_EN
      rr_last         <= 1'b1;
`endif
    end else begin
      iss_valid <= |grant;
      if (|grant) begin
        iss_port        <= gport;
        alu_operand_a_o <= gport ? req_operand_a_i[2*`DATA_WIDTH-1:`DATA_WIDTH] : req_operand_a_i[`DATA_WIDTH-1:0];
        alu_operand_b_o <= gport ? req_operand_b_i[2*`DATA_WIDTH-1:`DATA_WIDTH] : req_operand_b_i[`DATA_WIDTH-1:0];
        alu_operator_o  <= gport ? req_operator_i[7:4] : req_operator_i[3:0];
`ifdef ADMO_ALU_ARB_RR_EN
        rr_last         <= gport;
`endif
      end
      if (iss_valid && iss_port)
        rsp_result_o[2*`DATA_WIDTH-1:`DATA_WIDTH] <= alu_result_i;
      if (iss_valid && !iss_port)
        rsp_result_o[`DATA_WIDTH-1:0] <= alu_result_i;
      busy        <= (busy | grant) & ~(rsp_valid_o & rsp_ready_i);
      rsp_valid_o <= (rsp_valid_o & ~rsp_ready_i) | (iss_valid ? (iss_port ? 2'b10 : 2'b01) : 2'b00);
    end
  end
endmodule

// File: tb/tb_admo_alu_arb.sv
// tb_admo_alu_arb: directed and random stimulus against a cycle-level reference model of the arbiter.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd0
`define ALU_SUB 4'd1
`define ALU_AND 4'd2
`define ALU_OR  4'd3
`define ALU_XOR 4'd4
`define ALU_SLL 4'd5
`define ALU_SRL 4'd6
`define ALU_SRA 4'd7
`define ALU_LTS 4'd8
`define ALU_LTU 4'd9
`endif
module tb_admo_alu_arb;
  localparam int W = `DATA_WIDTH;
  logic clk_i = 1'b0, rst_ni = 1'b1;
  logic [1:0] req_valid_i = '0, req_ready_o, rsp_valid_o, rsp_ready_i = '0;
  logic [2*W-1:0] req_operand_a_i = '0, req_operand_b_i = '0, rsp_result_o;
  logic [7:0] req_operator_i = '0;
  logic [W-1:0] alu_operand_a_o, alu_operand_b_o, alu_result_i;
  logic [3:0] alu_operator_o;
  int checks = 0, errors = 0;
  always #5 clk_i = ~clk_i;

  function automatic logic [W-1:0] alu_f(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      `ALU_ADD: return a + b;
      `ALU_SUB: return a - b;
      `ALU_AND: return a & b;
      `ALU_OR:  return a | b;
      `ALU_XOR: return a ^ b;
      `ALU_SLL: return a << b[4:0];
      `ALU_SRL: return a >> b[4:0];
      `ALU_SRA: return $unsigned($signed(a) >>> b[4:0]);
      `ALU_LTS: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      `ALU_LTU: return (a < b) ? W'(1) : W'(0);
      default:  return '0;
    endcase
  endfunction

  assign alu_result_i = alu_f(alu_operator_o, alu_operand_a_o, alu_operand_b_o);

  admo_alu_arb dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_operand_a_i(req_operand_a_i), .req_operand_b_i(req_operand_b_i),
    .req_operator_i(req_operator_i),
    .alu_operand_a_o(alu_operand_a_o), .alu_operand_b_o(alu_operand_b_o),
    .alu_operator_o(alu_operator_o), .alu_result_i(alu_result_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o)
  );

  bit m_busy[2];
  int m_gcyc[2];
  logic [W-1:0] m_exp[2], m_held[2], m_a, m_b;
  logic [3:0] m_op;
  bit m_last;
  int cyc;
  logic [1:0] lg, p_pend;
  logic [67:0] p_snap[2];

  task automatic chk(string tag, logic [159:0] obs, logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [67:0] req_of(int i);
    return {req_operand_a_i[i*W +: W], req_operand_b_i[i*W +: W], req_operator_i[i*4 +: 4]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_gcyc[i] = 0; m_exp[i] = '0; m_held[i] = '0;
    end
    m_a = '0; m_b = '0; m_op = '0; m_last = 1; cyc = 0; lg = '0; p_pend = '0;
  endtask

  task automatic set_req(int i, bit v, logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
    req_valid_i[i] = v;
    req_operator_i[i*4 +: 4] = op;
    req_operand_a_i[i*W +: W] = a;
    req_operand_b_i[i*W +: W] = b;
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_req_ready"}, req_ready_o, 0);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
    chk({tag, "_rsp_result"}, rsp_result_o, 0);
    chk({tag, "_alu_a"}, alu_operand_a_o, 0);
    chk({tag, "_alu_b"}, alu_operand_b_o, 0);
    chk({tag, "_alu_op"}, alu_operator_o, 0);
  endtask

  // One clock cycle: compare every output with the model, then advance the model across the edge.
  task automatic tick();
    logic [1:0] el, g, vis;
    #1;
    for (int i = 0; i < 2; i++) begin
      vis[i] = m_busy[i] && (cyc - m_gcyc[i] >= 2);
      el[i]  = req_valid_i[i] && !m_busy[i];
      if (p_pend[i]) chk($sformatf("req_stable%0d", i), req_of(i), p_snap[i]);
    end
`ifdef ADMO_ALU_ARB_RR_EN
    g = (el == 2'b11) ? (m_last ? 2'b01 : 2'b10) : el;
`else
    g = (el == 2'b11) ? 2'b01 : el;
`endif
    chk("req_ready", req_ready_o, g);
    chk("rsp_valid", rsp_valid_o, vis);
    chk("rsp_result0", rsp_result_o[W-1:0], vis[0] ? m_exp[0] : m_held[0]);
    chk("rsp_result1", rsp_result_o[2*W-1:W], vis[1] ? m_exp[1] : m_held[1]);
    chk("alu_a", alu_operand_a_o, m_a);
    chk("alu_b", alu_operand_b_o, m_b);
    chk("alu_op", alu_operator_o, m_op);
    for (int i = 0; i < 2; i++) begin
      p_pend[i] = req_valid_i[i] && !g[i];
      p_snap[i] = req_of(i);
    end
    @(posedge clk_i);
    for (int i = 0; i < 2; i++) begin
      if (vis[i] && rsp_ready_i[i]) begin
        m_busy[i] = 0;
        m_held[i] = m_exp[i];
      end
      if (g[i]) begin
        m_busy[i] = 1;
        m_gcyc[i] = cyc;
        m_op = req_operator_i[i*4 +: 4];
        m_a  = req_operand_a_i[i*W +: W];
        m_b  = req_operand_b_i[i*W +: W];
        m_exp[i] = alu_f(m_op, m_a, m_b);
        m_last = (i == 1);
      end
    end
    lg = g;
    cyc++;
    @(negedge clk_i);
  endtask

  logic [3:0] ops[10] = '{`ALU_ADD, `ALU_SUB, `ALU_AND, `ALU_OR, `ALU_XOR,
                          `ALU_SLL, `ALU_SRL, `ALU_SRA, `ALU_LTS, `ALU_LTU};

  initial begin
    model_reset();
    #1 rst_ni = 1'b0;
    req_valid_i = 2'b11;
    @(negedge clk_i);
    reset_checks("reset");
    @(negedge clk_i);
    req_valid_i = 2'b00;
    rst_ni = 1'b1;
    tick();
    // Single port-0 add with an always-ready consumer.
    rsp_ready_i = 2'b11;
    set_req(0, 1, `ALU_ADD, 5, 3);
    tick();
    req_valid_i[0] = 1'b0;
    tick();
    tick();
    chk("add_result", rsp_result_o[W-1:0], 8);
    tick();
    tick();
    // Continuous contention between both ports.
    set_req(0, 1, `ALU_SUB, 10, 4);
    set_req(1, 1, `ALU_SLL, 1, 4);
    repeat (12) tick();
    chk("sub_result", rsp_result_o[W-1:0], 6);
    chk("sll_result", rsp_result_o[2*W-1:W], 16);
    req_valid_i = 2'b00;
    repeat (3) tick();
    // Port 1 response held while its consumer stalls.
    rsp_ready_i = 2'b01;
    set_req(1, 1, `ALU_LTS, 32'hFFFF_FFFF, 1);
    tick();
    set_req(1, 1, `ALU_ADD, 32'h1234, 32'h1);
    repeat (10) tick();
    chk("lts_result", rsp_result_o[2*W-1:W], 1);
    rsp_ready_i = 2'b11;
    repeat (5) tick();
    req_valid_i = 2'b00;
    repeat (3) tick();
    // Random traffic; requests only change once accepted or idle.
    repeat (400) begin
      for (int i = 0; i < 2; i++)
        if (!(req_valid_i[i] && !lg[i]))
          set_req(i, $urandom_range(0, 9) < 7, ops[$urandom_range(0, 9)],
                  ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom),
                  ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 40)) : W'($urandom));
      rsp_ready_i = 2'($urandom);
      tick();
    end
    req_valid_i = 2'b00;
    rsp_ready_i = 2'b11;
    repeat (4) tick();
    // Reset one cycle after a port-0 handshake discards the in-flight op.
    set_req(0, 1, `ALU_ADD, 7, 9);
    tick();
    rst_ni = 1'b0;
    #1;
    reset_checks("async_reset");
    @(negedge clk_i);
    req_valid_i = 2'b00;
    rst_ni = 1'b1;
    model_reset();
    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
